// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: queue entry layout and source identifiers.
// Entries carry WB_XLEN data bits; instances with a narrower XLEN zero-extend on push.
package wb_pkg;

    localparam int unsigned WB_XLEN = 64;
    localparam int unsigned NUM_SRC = 3;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_CSR = 2'd1,
        SRC_LSU = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [4:0]         addr;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: three result sources in, one register-file write port out,
// plus the decode hazard query.
interface wb_arbiter_if #(
    parameter int unsigned XLEN = 64
) ();

    logic            alu_wb_vld;
    logic [4:0]      alu_wb_addr;
    logic [XLEN-1:0] alu_wb_data;
    logic            csr_wb_vld;
    logic [4:0]      csr_wb_addr;
    logic [XLEN-1:0] csr_wb_data;
    logic            lsu_wb_vld;
    logic [4:0]      lsu_wb_addr;
    logic [XLEN-1:0] lsu_wb_data;

    logic            rf_wen;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            wb_stall;
    logic            wb_overflow;
    logic [63:0]     retire_cnt;

    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            rs1_busy;
    logic            rs2_busy;

    modport master (
        output alu_wb_vld, alu_wb_addr, alu_wb_data,
        output csr_wb_vld, csr_wb_addr, csr_wb_data,
        output lsu_wb_vld, lsu_wb_addr, lsu_wb_data,
        output rs1_addr, rs2_addr,
        input  rf_wen, rf_waddr, rf_wdata, wb_stall, wb_overflow, retire_cnt,
        input  rs1_busy, rs2_busy
    );

    modport slave (
        input  alu_wb_vld, alu_wb_addr, alu_wb_data,
        input  csr_wb_vld, csr_wb_addr, csr_wb_data,
        input  lsu_wb_vld, lsu_wb_addr, lsu_wb_data,
        input  rs1_addr, rs2_addr,
        output rf_wen, rf_waddr, rf_wdata, wb_stall, wb_overflow, retire_cnt,
        output rs1_busy, rs2_busy
    );

endinterface

// File: rtl/wb_fifo.sv
// Per-source pending writeback queue. Accepts push and pop in the same cycle even when full;
// exposes per-slot valid bits and addresses so the top can answer hazard queries.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  wb_entry_t                     push_entry,
    input  logic                          pop,
    output wb_entry_t                     head,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow,
    output logic [DEPTH-1:0]              entry_vld,
    output logic [DEPTH-1:0][4:0]         entry_addr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    wb_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push_ok, pop_ok;
    logic [AW-1:0]   offset;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign head     = mem_q[rd_ptr_q];
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign overflow = push && full && !pop_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset: slot validity comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_entry;
    end

    always_comb begin
        entry_vld  = '0;
        entry_addr = '0;
        offset     = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            offset        = AW'(i) - rd_ptr_q;
            entry_vld[i]  = ({1'b0, offset} < count_q);
            entry_addr[i] = mem_q[i].addr;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: three source queues drained one entry per cycle (lsu > csr > alu) into
// a registered register-file write port. Define WB_HAZARD_EN to enable rs1/rs2 busy compare.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 64
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic      [NUM_SRC-1:0]                  push_vld;
    wb_entry_t [NUM_SRC-1:0]                  push_entry;
    logic      [NUM_SRC-1:0]                  pop;
    wb_entry_t [NUM_SRC-1:0]                  head;
    logic      [NUM_SRC-1:0][CW-1:0]          count;
    logic      [NUM_SRC-1:0]                  full, empty, ovf_evt;
    logic      [NUM_SRC-1:0][DEPTH-1:0]       entry_vld;
    logic      [NUM_SRC-1:0][DEPTH-1:0][4:0]  entry_addr;

    wb_src_e         sel;
    logic            pop_any;
    wb_entry_t       head_sel;
    logic            rf_wen_q;
    logic [4:0]      rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_q;
    logic            overflow_q;
    logic [63:0]     retire_cnt_q;
    logic            stall;

    // x0 writes are architecturally dead, so they never enter a queue.
    always_comb begin
        push_vld[SRC_ALU]   = bus.alu_wb_vld && (bus.alu_wb_addr != 5'd0);
        push_vld[SRC_CSR]   = bus.csr_wb_vld && (bus.csr_wb_addr != 5'd0);
        push_vld[SRC_LSU]   = bus.lsu_wb_vld && (bus.lsu_wb_addr != 5'd0);
        push_entry[SRC_ALU] = '{addr: bus.alu_wb_addr, data: WB_XLEN'(bus.alu_wb_data)};
        push_entry[SRC_CSR] = '{addr: bus.csr_wb_addr, data: WB_XLEN'(bus.csr_wb_data)};
        push_entry[SRC_LSU] = '{addr: bus.lsu_wb_addr, data: WB_XLEN'(bus.lsu_wb_data)};
    end

    for (genvar s = 0; s < int'(NUM_SRC); s++) begin : g_fifo
        wb_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push       (push_vld[s]),
            .push_entry (push_entry[s]),
            .pop        (pop[s]),
            .head       (head[s]),
            .count      (count[s]),
            .full       (full[s]),
            .empty      (empty[s]),
            .overflow   (ovf_evt[s]),
            .entry_vld  (entry_vld[s]),
            .entry_addr (entry_addr[s])
        );
    end

    always_comb begin
        pop     = '0;
        sel     = SRC_ALU;
        pop_any = 1'b1;
        if (!empty[SRC_LSU]) begin
            sel = SRC_LSU;
        end else if (!empty[SRC_CSR]) begin
            sel = SRC_CSR;
        end else if (!empty[SRC_ALU]) begin
            sel = SRC_ALU;
        end else begin
            pop_any = 1'b0;
        end
        pop[sel] = pop_any;
        head_sel = head[sel];
    end

    always_comb begin
        stall = 1'b0;
        for (int s = 0; s < int'(NUM_SRC); s++) begin
            if (count[s] >= CW'(DEPTH - 1)) stall = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            overflow_q   <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            rf_wen_q     <= pop_any;
            retire_cnt_q <= retire_cnt_q + 64'(pop_any);
            overflow_q   <= overflow_q | (|ovf_evt);
            if (pop_any) begin
                rf_waddr_q <= head_sel.addr;
                rf_wdata_q <= head_sel.data[XLEN-1:0];
            end
        end
    end

    assign bus.rf_wen      = rf_wen_q;
    assign bus.rf_waddr    = rf_waddr_q;
    assign bus.rf_wdata    = rf_wdata_q;
    assign bus.wb_stall    = stall;
    assign bus.wb_overflow = overflow_q;
    assign bus.retire_cnt  = retire_cnt_q;

`ifdef WB_HAZARD_EN
    // A register is busy while any queued entry or the in-flight write targets it.
    always_comb begin
        bus.rs1_busy = rf_wen_q && (rf_waddr_q == bus.rs1_addr);
        bus.rs2_busy = rf_wen_q && (rf_waddr_q == bus.rs2_addr);
        for (int s = 0; s < int'(NUM_SRC); s++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (entry_vld[s][i] && (entry_addr[s][i] == bus.rs1_addr)) bus.rs1_busy = 1'b1;
                if (entry_vld[s][i] && (entry_addr[s][i] == bus.rs2_addr)) bus.rs2_busy = 1'b1;
            end
        end
        if (bus.rs1_addr == 5'd0) bus.rs1_busy = 1'b0;
        if (bus.rs2_addr == 5'd0) bus.rs2_busy = 1'b0;
    end
`else
    logic unused_hazard;
    assign unused_hazard = ^{bus.rs1_addr, bus.rs2_addr, entry_vld, entry_addr, full};
    assign bus.rs1_busy  = 1'b0;
    assign bus.rs2_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a scoreboard of expected register writes is filled as
// results are pushed and drained by a monitor whenever rf_wen is seen.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned XLEN  = 64;
`ifdef WB_HAZARD_EN
    localparam logic HAZ = 1'b1;
`else
    localparam logic HAZ = 1'b0;
`endif

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_retire = '0;
    exp_t        sb [$];
    exp_t        mon_e;

    wb_arbiter_if #(.XLEN(XLEN)) bus ();

    wb_arbiter #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are registered, so sampling on the falling edge is race-free.
    always @(negedge clk) begin
        if (bus.rf_wen === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_wen", 64'(bus.rf_wen), 64'd0);
            end else begin
                mon_e      = sb.pop_front();
                exp_retire = exp_retire + 64'd1;
                chk("rf_waddr", 64'(bus.rf_waddr), 64'(mon_e.addr));
                chk("rf_wdata", bus.rf_wdata, mon_e.data);
                chk("retire_cnt", bus.retire_cnt, exp_retire);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_wb_vld = 1'b0;
        bus.csr_wb_vld = 1'b0;
        bus.lsu_wb_vld = 1'b0;
    endtask

    task automatic push(input wb_src_e src, input logic [4:0] a, input logic [63:0] d,
                        input logic expect_write);
        case (src)
            SRC_ALU: begin bus.alu_wb_vld = 1'b1; bus.alu_wb_addr = a; bus.alu_wb_data = d; end
            SRC_CSR: begin bus.csr_wb_vld = 1'b1; bus.csr_wb_addr = a; bus.csr_wb_data = d; end
            default: begin bus.lsu_wb_vld = 1'b1; bus.lsu_wb_addr = a; bus.lsu_wb_data = d; end
        endcase
        if (expect_write) sb.push_back('{addr: a, data: d});
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        chk(tag, 64'(sb.size()), 64'd0);
        repeat (3) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        bus.alu_wb_addr = '0; bus.alu_wb_data = '0;
        bus.csr_wb_addr = '0; bus.csr_wb_data = '0;
        bus.lsu_wb_addr = '0; bus.lsu_wb_data = '0;
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd0;
        rst = 1'b1;
        repeat (3) step();
        chk("rst_wen", 64'(bus.rf_wen), 64'd0);
        chk("rst_waddr", 64'(bus.rf_waddr), 64'd0);
        chk("rst_wdata", bus.rf_wdata, 64'd0);
        chk("rst_overflow", 64'(bus.wb_overflow), 64'd0);
        chk("rst_retire", bus.retire_cnt, 64'd0);
        chk("rst_stall", 64'(bus.wb_stall), 64'd0);
        chk("rst_busy1", 64'(bus.rs1_busy), 64'd0);
        rst = 1'b0;
        step();

        // Single ALU push: write appears one cycle after the push edge.
        push(SRC_ALU, 5'd5, 64'h11, 1'b1);
        step(); idle();
        chk("single_no_wen_yet", 64'(bus.rf_wen), 64'd0);
        step();
        chk("single_wen", 64'(bus.rf_wen), 64'd1);
        chk("single_retire", bus.retire_cnt, 64'd1);
        drain("single_drain");

        // Same-cycle push from all sources drains lsu, csr, alu.
        push(SRC_LSU, 5'd3, 64'hC, 1'b1);
        push(SRC_CSR, 5'd2, 64'hB, 1'b1);
        push(SRC_ALU, 5'd1, 64'hA, 1'b1);
        step(); idle();
        drain("prio_drain");
        chk("prio_retire", bus.retire_cnt, 64'd4);

        // x0 write is discarded.
        push(SRC_ALU, 5'd0, 64'hFF, 1'b0);
        step(); idle();
        repeat (3) step();
        chk("x0_retire", bus.retire_cnt, 64'd4);
        chk("x0_wen", 64'(bus.rf_wen), 64'd0);
        chk("x0_stall", 64'(bus.wb_stall), 64'd0);

        // Full ALU queue pushed while it pops: accepted, no overflow.
        push(SRC_LSU, 5'd10, 64'h100, 1'b1);
        push(SRC_ALU, 5'd20, 64'h200, 1'b0);
        sb.push_back('{addr: 5'd11, data: 64'h101});
        sb.push_back('{addr: 5'd20, data: 64'h200});
        sb.push_back('{addr: 5'd21, data: 64'h201});
        sb.push_back('{addr: 5'd22, data: 64'h202});
        step();
        chk("fullpp_stall", 64'(bus.wb_stall), 64'd1);
        push(SRC_LSU, 5'd11, 64'h101, 1'b0);
        push(SRC_ALU, 5'd21, 64'h201, 1'b0);
        step(); idle();
        step();
        push(SRC_ALU, 5'd22, 64'h202, 1'b0);
        step(); idle();
        chk("fullpp_overflow", 64'(bus.wb_overflow), 64'd0);
        drain("fullpp_drain");
        chk("fullpp_retire", bus.retire_cnt, 64'd9);

        // Third ALU push into a full, non-popping queue is lost and sets overflow.
        push(SRC_LSU, 5'd12, 64'h300, 1'b1);
        push(SRC_ALU, 5'd23, 64'h400, 1'b0);
        sb.push_back('{addr: 5'd13, data: 64'h301});
        sb.push_back('{addr: 5'd14, data: 64'h302});
        sb.push_back('{addr: 5'd23, data: 64'h400});
        sb.push_back('{addr: 5'd24, data: 64'h401});
        step();
        chk("ovf_stall", 64'(bus.wb_stall), 64'd1);
        push(SRC_LSU, 5'd13, 64'h301, 1'b0);
        push(SRC_ALU, 5'd24, 64'h401, 1'b0);
        step();
        chk("ovf_not_yet", 64'(bus.wb_overflow), 64'd0);
        push(SRC_LSU, 5'd14, 64'h302, 1'b0);
        push(SRC_ALU, 5'd25, 64'h402, 1'b0);
        step(); idle();
        chk("ovf_set", 64'(bus.wb_overflow), 64'd1);
        drain("ovf_drain");
        chk("ovf_retire", bus.retire_cnt, 64'd14);
        chk("ovf_sticky", 64'(bus.wb_overflow), 64'd1);

        // Hazard query tracks a pending LSU write to x7.
        bus.rs1_addr = 5'd7;
        push(SRC_LSU, 5'd7, 64'h77, 1'b1);
        step(); idle();
        chk("haz_queued", 64'(bus.rs1_busy), 64'(HAZ));
        chk("haz_rs2_x0", 64'(bus.rs2_busy), 64'd0);
        step();
        chk("haz_inflight_wen", 64'(bus.rf_wen), 64'd1);
        chk("haz_inflight", 64'(bus.rs1_busy), 64'(HAZ));
        step();
        chk("haz_clear", 64'(bus.rs1_busy), 64'd0);
        bus.rs1_addr = 5'd0;
        drain("haz_drain");

        // Reset mid-operation discards pending entries.
        push(SRC_ALU, 5'd1, 64'hA1, 1'b0);
        push(SRC_CSR, 5'd2, 64'hB2, 1'b0);
        step(); idle();
        chk("rstmid_stall", 64'(bus.wb_stall), 64'd1);
        rst = 1'b1;
        exp_retire = '0;
        #1;
        chk("rstmid_wen", 64'(bus.rf_wen), 64'd0);
        chk("rstmid_retire", bus.retire_cnt, 64'd0);
        chk("rstmid_overflow", 64'(bus.wb_overflow), 64'd0);
        push(SRC_ALU, 5'd3, 64'hC3, 1'b0);
        repeat (2) step();
        chk("rstmid_wen_held", 64'(bus.rf_wen), 64'd0);
        idle();
        rst = 1'b0;
        repeat (4) step();
        chk("rstmid_empty_stall", 64'(bus.wb_stall), 64'd0);
        chk("rstmid_retire_after", bus.retire_cnt, 64'd0);
        chk("rstmid_sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
